// File: rtl/ahb_gpio_pkg.sv
// Shared types for the two-requester AHB-Lite GPIO master: FSM states, HTRANS codes, command latch.
// Pure declarations; no latency or backpressure of its own.
package ahb_gpio_pkg;

  localparam int AHB_ADDR_W = 32;
  localparam int AHB_DATA_W = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic                  write;
    logic [AHB_ADDR_W-1:0] addr;
    logic [AHB_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/ahb_gpio_master_arb_rr_arb2.sv
// Two-way round-robin grant; combinational gnt, pointer updates on the advance edge.
// No backpressure: a zero req vector yields a zero grant and leaves the pointer alone.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    last_d = last_q;
    if (advance && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  // Pointer starts at "last=1" so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ahb_gpio_master_arb.sv
// Round-robin AHB-Lite master for the GPIO slave: accept N, address N+1, data N+2, rsp_valid N+3.
// One transfer in flight; req*_ready only pulses in IDLE, HREADYOUT=0 stretches the current phase.
module ahb_gpio_master_arb
  import ahb_gpio_pkg::*;
#(
  parameter int ADDR_W = AHB_ADDR_W,
  parameter int DATA_W = AHB_DATA_W
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              HSEL,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HREADY,
  input  logic              HREADYOUT,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              PARITYERR
);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              owner_q, owner_d;
  logic              hsel_q, hsel_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              idle;
  logic [1:0]        gnt;

  // Requests outside IDLE are masked so nothing can be granted mid-transfer.
  assign idle = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .req     ({req1_valid & idle, req0_valid & idle}),
    .advance (idle),
    .gnt     (gnt)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    owner_d     = owner_q;
    hsel_d      = hsel_q;
    htrans_d    = htrans_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          owner_d  = gnt[1];
          cmd_d    = gnt[1] ? '{req1_write, req1_addr, req1_wdata}
                            : '{req0_write, req0_addr, req0_wdata};
          hsel_d   = 1'b1;
          htrans_d = HTRANS_NONSEQ;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADYOUT) begin
          hsel_d   = 1'b0;
          htrans_d = HTRANS_IDLE;
          hwdata_d = cmd_q.wdata;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (HREADYOUT) begin
          if (!cmd_q.write) begin
            rsp_rdata_d = HRDATA;
          end
          rsp_err_d            = PARITYERR;
          rsp_valid_d[owner_q] = 1'b1;
          hwdata_d             = '0;
          state_d              = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      owner_q     <= 1'b0;
      hsel_q      <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      hwdata_q    <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      owner_q     <= owner_d;
      hsel_q      <= hsel_d;
      htrans_q    <= htrans_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign HSEL       = hsel_q;
  assign HADDR      = cmd_q.addr;
  assign HTRANS     = htrans_q;
  assign HWRITE     = cmd_q.write;
  assign HWDATA     = hwdata_q;
  assign HREADY     = HREADYOUT;

endmodule

// File: tb/tb_ahb_gpio_master_arb.sv
// Directed bench for ahb_gpio_master_arb: reset, write, waited read, contention, parity, mid-transfer reset.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_ahb_gpio_master_arb;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req0_valid, req0_ready, req0_write;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_ready, req1_write;
  logic [31:0] req1_addr, req1_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        PARITYERR;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_gpio_master_arb dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .PARITYERR(PARITYERR)
  );

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    HREADYOUT = 1'b1; HRDATA = 0; PARITYERR = 0;
    repeat (5) tick();
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %b want 00", HTRANS); end
    checks++; if (HSEL !== 1'b0) begin errors++; $display("FAIL reset_hsel: got %b want 0", HSEL); end
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready}); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL reset_hwdata: got %h want 0", HWDATA); end
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    req0_write = 1; req0_addr = 32'h4; req0_wdata = 32'hFF; req0_valid = 1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL wr_ready: got %b want 01", {req1_ready, req0_ready}); end
    tick(); req0_valid = 0;
    checks++; if (HTRANS !== 2'b10 || HSEL !== 1'b1) begin errors++; $display("FAIL wr_addr_phase: htrans %b hsel %b want 10 1", HTRANS, HSEL); end
    checks++; if (HADDR !== 32'h4 || HWRITE !== 1'b1) begin errors++; $display("FAIL wr_haddr: haddr %h hwrite %b want 4 1", HADDR, HWRITE); end
    checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL wr_hwdata_addr: got %h want 0", HWDATA); end
    tick();
    checks++; if (HTRANS !== 2'b00 || HSEL !== 1'b0) begin errors++; $display("FAIL wr_data_phase: htrans %b hsel %b want 00 0", HTRANS, HSEL); end
    checks++; if (HWDATA !== 32'hFF) begin errors++; $display("FAIL wr_hwdata: got %h want ff", HWDATA); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_rsp_early: got %b want 00", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL wr_rsp_valid: got %b want 01", rsp_valid); end
    checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL wr_hwdata_clear: got %h want 0", HWDATA); end
    tick();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_rsp_pulse: got %b want 00", rsp_valid); end
  endtask

  task automatic test_read_waits();
    req1_write = 0; req1_addr = 32'h0; req1_wdata = 32'h0; HRDATA = 32'hA5A5; req1_valid = 1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL rd_ready: got %b want 10", {req1_ready, req0_ready}); end
    tick(); req1_valid = 0;
    checks++; if (HTRANS !== 2'b10 || HWRITE !== 1'b0) begin errors++; $display("FAIL rd_addr_phase: htrans %b hwrite %b want 10 0", HTRANS, HWRITE); end
    tick(); HREADYOUT = 0;
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rd_data_phase: htrans %b want 00", HTRANS); end
    tick();
    checks++; if (rsp_valid !== 2'b00 || HSEL !== 1'b0) begin errors++; $display("FAIL rd_wait1: rsp %b hsel %b want 00 0", rsp_valid, HSEL); end
    tick(); HREADYOUT = 1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_wait2: rsp %b want 00", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rd_rsp_valid: got %b want 10", rsp_valid); end
    checks++; if (rsp_rdata !== 32'hA5A5) begin errors++; $display("FAIL rd_rsp_rdata: got %h want a5a5", rsp_rdata); end
    tick();
  endtask

  task automatic test_contention();
    int   g = 0;
    int   last_c = -1;
    int   exp_id = 0;
    int   prev_id = -1;
    logic [1:0] exp_rsp;
    req0_write = 1; req0_addr = 32'h20; req0_wdata = 32'h11;
    req1_write = 1; req1_addr = 32'h24; req1_wdata = 32'h22;
    req0_valid = 1; req1_valid = 1;
    #1;
    for (int c = 0; c < 24 && g < 4; c++) begin
      if (rsp_valid !== 2'b00) begin
        exp_rsp = (prev_id == 1) ? 2'b10 : 2'b01;
        checks++; if (prev_id < 0 || rsp_valid !== exp_rsp) begin errors++; $display("FAIL cont_rsp: got %b want %b", rsp_valid, exp_rsp); end
      end
      if (req0_ready || req1_ready) begin
        checks++; if (req0_ready && req1_ready) begin errors++; $display("FAIL cont_onehot: got 11 want one-hot"); end
        checks++; if (int'(req1_ready) != exp_id) begin errors++; $display("FAIL cont_order: grant %0d got %0d want %0d", g, int'(req1_ready), exp_id); end
        if (last_c >= 0) begin
          checks++; if (c - last_c != 3) begin errors++; $display("FAIL cont_gap: got %0d cycles want 3", c - last_c); end
        end
        last_c  = c;
        prev_id = req1_ready ? 1 : 0;
        exp_id  = 1 - exp_id;
        g++;
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    checks++; if (g != 4) begin errors++; $display("FAIL cont_count: got %0d grants want 4", g); end
    tick(); tick();
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL cont_last_rsp: got %b want 10", rsp_valid); end
    tick();
  endtask

  task automatic test_parity();
    req0_write = 0; req0_addr = 32'h8; HRDATA = 32'h1234; PARITYERR = 1; req0_valid = 1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL par_ready: got %b want 1", req0_ready); end
    tick(); req0_valid = 0;
    tick(); tick();
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1) begin errors++; $display("FAIL par_err: rsp %b err %b want 01 1", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 32'h1234) begin errors++; $display("FAIL par_rdata: got %h want 1234", rsp_rdata); end
    PARITYERR = 0; HRDATA = 32'hDEAD;
    req0_write = 1; req0_addr = 32'hC; req0_wdata = 32'h77; req0_valid = 1;
    tick(); req0_valid = 0;
    tick(); tick();
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0) begin errors++; $display("FAIL par_wr_rsp: rsp %b err %b want 01 0", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 32'h1234) begin errors++; $display("FAIL par_wr_hold: got %h want 1234", rsp_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    req1_write = 1; req1_addr = 32'hC; req1_wdata = 32'h55; HREADYOUT = 0; req1_valid = 1;
    tick(); req1_valid = 0;
    checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL rst_mid_addr: htrans %b want 10", HTRANS); end
    tick();
    #2 HRESETn = 0;
    #1;
    checks++; if (HTRANS !== 2'b00 || HSEL !== 1'b0) begin errors++; $display("FAIL rst_mid_async: htrans %b hsel %b want 00 0", HTRANS, HSEL); end
    tick(); tick();
    HRESETn = 1; HREADYOUT = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid !== 2'b00) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_norsp: got 1 want 0"); end
    req0_write = 0; req0_addr = 32'h10; HRDATA = 32'hBEEF; req0_valid = 1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rst_next_ready: got %b want 1", req0_ready); end
    tick(); req0_valid = 0;
    tick(); tick();
    checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hBEEF) begin errors++; $display("FAIL rst_next_rsp: rsp %b rdata %h want 01 beef", rsp_valid, rsp_rdata); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_waits();
    test_contention();
    test_parity();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
